// File: rtl/mem_req_arb_pkg.sv
// Shared constants and types for the memory request arbiter.
//   PA_WIDTH   : physical address width
//   LINE_BYTES : bytes per cache line carried on the request/response data paths
//   ID_WIDTH   : transaction ID width; outstanding depth is 2**ID_WIDTH
//   ARB_RR / ARB_FIXED : arbitration mode selectors
//   mem_req_t  : payload held in the memory-side output slot
package mem_req_arb_pkg;

  localparam int unsigned PA_WIDTH   = 32;
  localparam int unsigned LINE_BYTES = 8;
  localparam int unsigned ID_WIDTH   = 3;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  typedef struct packed {
    logic [PA_WIDTH-1:0]     addr;
    logic [LINE_BYTES*8-1:0] data;
    logic                    write;
    logic [ID_WIDTH-1:0]     id;
  } mem_req_t;

endpackage

// File: rtl/mem_req_arb_rr_picker.sv
// Round-robin picker: searches req starting at last+1 and wrapping mod N.
//   req   in  N             request vector
//   last  in  clog2(N)      index granted most recently
//   gnt   out N             one-hot grant (zero when no request)
//   idx   out clog2(N)      index of the granted channel
//   any   out 1             at least one request present
module rr_picker #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int unsigned c;
    logic        found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int unsigned j = 1; j <= N; j++) begin
      c = (32'(last) + j) % N;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = IDX_W'(c);
      end
    end
    any = found;
  end

endmodule

// File: rtl/mem_req_arb.sv
// N-channel memory request arbiter with transaction-ID tagging and response steering.
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_req_valid/o_req_ready    per-channel request handshake (ready one-hot or zero)
//   i_req_addr/data/write      per-channel request payload, channel k in slice k
//   o_mem_valid/i_mem_ready    registered memory-side request handshake
//   o_mem_addr/data/write/id   memory request payload and transaction ID
//   i_rsp_valid/id/data        memory response (one per request)
//   o_rsp_valid/o_rsp_data     one-hot response strobe to owner, shared line
//   o_rsp_err                  pulse when a response ID is not in flight
//   o_inflight                 count of outstanding IDs
module mem_req_arb
  import mem_req_arb_pkg::*;
#(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned ARB_MODE = ARB_RR
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CH-1:0]            i_req_valid,
  output logic [N_CH-1:0]            o_req_ready,
  input  logic [N_CH*PA_WIDTH-1:0]   i_req_addr,
  input  logic [N_CH*LINE_BYTES*8-1:0] i_req_data,
  input  logic [N_CH-1:0]            i_req_write,
  output logic                       o_mem_valid,
  input  logic                       i_mem_ready,
  output logic [PA_WIDTH-1:0]        o_mem_addr,
  output logic [LINE_BYTES*8-1:0]    o_mem_data,
  output logic                       o_mem_write,
  output logic [ID_WIDTH-1:0]        o_mem_id,
  input  logic                       i_rsp_valid,
  input  logic [ID_WIDTH-1:0]        i_rsp_id,
  input  logic [LINE_BYTES*8-1:0]    i_rsp_data,
  output logic [N_CH-1:0]            o_rsp_valid,
  output logic [LINE_BYTES*8-1:0]    o_rsp_data,
  output logic                       o_rsp_err,
  output logic [ID_WIDTH:0]          o_inflight
);

  localparam int unsigned CH_W  = $clog2(N_CH);
  localparam int unsigned DEPTH = 2 ** ID_WIDTH;
  localparam int unsigned DW    = LINE_BYTES * 8;

  mem_req_t            slot_q;
  logic                slot_valid_q;
  logic [ID_WIDTH-1:0] id_cnt_q;
  logic [CH_W-1:0]     rr_last_q;
  logic [DEPTH-1:0]    inflight_q, inflight_d;
  logic [CH_W-1:0]     owner_q [DEPTH];
  logic [N_CH-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]       rsp_data_q;
  logic                rsp_err_q;
  logic [ID_WIDTH:0]   cnt_q, cnt_d;

  logic [N_CH-1:0] gnt;
  logic [CH_W-1:0] win_idx;
  logic            any_req;
  logic [CH_W-1:0] search_last;
  logic            accept;
  logic            rsp_hit;
  mem_req_t        sel;

  // Fixed priority is a search that always starts at channel 0.
  assign search_last = (ARB_MODE == ARB_FIXED) ? CH_W'(N_CH - 1) : rr_last_q;

  rr_picker #(
    .N     (N_CH),
    .IDX_W (CH_W)
  ) u_picker (
    .req  (i_req_valid),
    .last (search_last),
    .gnt  (gnt),
    .idx  (win_idx),
    .any  (any_req)
  );

  // Full looks only at registered state: a release this cycle does not free id_cnt_q yet.
  assign accept      = (!slot_valid_q || i_mem_ready) && !inflight_q[id_cnt_q] && any_req;
  assign o_req_ready = accept ? gnt : '0;
  assign rsp_hit     = i_rsp_valid && inflight_q[i_rsp_id];

  always_comb begin
    sel = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (gnt[k]) begin
        sel.addr  = i_req_addr[k*PA_WIDTH +: PA_WIDTH];
        sel.data  = i_req_data[k*DW +: DW];
        sel.write = i_req_write[k];
      end
    end
    sel.id = id_cnt_q;
  end

  always_comb begin
    inflight_d  = inflight_q;
    rsp_valid_d = '0;
    cnt_d       = cnt_q;
    if (rsp_hit) begin
      inflight_d[i_rsp_id]          = 1'b0;
      rsp_valid_d[owner_q[i_rsp_id]] = 1'b1;
    end
    // A hit never targets id_cnt_q on an accept cycle, since accept requires that bit clear.
    if (accept) begin
      inflight_d[id_cnt_q] = 1'b1;
    end
    unique case ({accept, rsp_hit})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q       <= '0;
      slot_valid_q <= 1'b0;
      id_cnt_q     <= '0;
      rr_last_q    <= CH_W'(N_CH - 1);
      inflight_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      cnt_q        <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        owner_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        slot_q            <= sel;
        slot_valid_q      <= 1'b1;
        owner_q[id_cnt_q] <= win_idx;
        id_cnt_q          <= id_cnt_q + 1'b1;
        rr_last_q         <= win_idx;
      end else if (i_mem_ready) begin
        slot_valid_q <= 1'b0;
      end
      inflight_q  <= inflight_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= i_rsp_valid && !rsp_hit;
      if (rsp_hit) begin
        rsp_data_q <= i_rsp_data;
      end
      cnt_q <= cnt_d;
    end
  end

  assign o_mem_valid = slot_valid_q;
  assign o_mem_addr  = slot_q.addr;
  assign o_mem_data  = slot_q.data;
  assign o_mem_write = slot_q.write;
  assign o_mem_id    = slot_q.id;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_inflight  = cnt_q;

endmodule
